// File: rtl/dmem_line_ctrl.sv
// Line-granular backing memory behind the data cache: serialised 256-bit
// reads and write-backs, each completing after a fixed latency with a one-cycle ack.
`timescale 1ns/1ps

module dmem_line_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                wr_r;
  logic [IDX_W-1:0]    idx_r;
  logic [LINE_W-1:0]   wdata_r;
  logic [LINE_W-1:0]   rdata_r;
  logic                ack_r;
  logic                busy_r;
  logic                mem_we_s;
  logic                unused_addr_s;

  logic [LINE_W-1:0]   mem_r [DEPTH];

  // Offset bits and bits above the line index play no part in addressing.
  assign unused_addr_s = ^{addr_i[ADDR_W-1:5+IDX_W], addr_i[4:0]};

  // Array write strobe: only on the completing edge of a latched write.
  always_comb begin
    mem_we_s = 1'b0;
    if ((state_r == BUSY) && (cnt_r == CNT_LAST) && wr_r) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Storage array; deliberately not reset. A reset aborts via state_r -> IDLE.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

  // Request FSM: accept in IDLE, count LATENCY edges in BUSY, pulse ack in ACK.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      wr_r    <= 1'b0;
      idx_r   <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ack_r <= 1'b0;
          if (enable_i) begin
            wr_r    <= write_i;
            idx_r   <= addr_i[5+IDX_W-1:5];
            wdata_r <= data_i;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= BUSY;
          end
        end
        BUSY: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) begin
            if (!wr_r) begin
              rdata_r <= mem_r[idx_r];
            end
            ack_r   <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ACK;
          end
        end
        ACK: begin
          // enable_i is intentionally not sampled here: one ack per request.
          ack_r   <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          ack_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign ack_o  = ack_r;
  assign busy_o = busy_r;
  assign data_o = rdata_r;

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Directed self-checking bench for dmem_line_ctrl at default parameters
// (LATENCY=10, DEPTH=512).
`timescale 1ns/1ps

module tb_dmem_line_ctrl;

  logic         clk_i;
  logic         rst_i;
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_o;
  logic [255:0] data_o;
  logic         busy_o;

  int total;
  int bad;

  dmem_line_ctrl dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .ack_o    (ack_o),
    .data_o   (data_o),
    .busy_o   (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Issue one request, drop enable after acceptance, wait (bounded) for ack.
  // lat = edges after acceptance until ack seen (-1 on timeout).
  task automatic run_req(input logic w, input logic [31:0] a, input logic [255:0] d,
                         output int lat, output logic [255:0] rd, output logic ack_next);
    write_i  = w;
    addr_i   = a;
    data_i   = d;
    enable_i = 1'b1;
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    lat = -1;
    rd  = '0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk_i); #1;
      if (ack_o === 1'b1) begin
        lat = n;
        rd  = data_o;
      end
    end
    @(posedge clk_i); #1;
    ack_next = ack_o;
  endtask

  task automatic test_reset;
    int acks;
    enable_i = 1'b0; write_i = 1'b0; addr_i = 32'h0; data_i = '0;
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    total++;
    if (ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", ack_o); end
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    total++;
    if (data_o !== 256'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_o); end
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      if (ack_o === 1'b1 || busy_o === 1'b1) acks++;
    end
    total++;
    if (acks != 0) begin bad++; $display("FAIL idle_no_ack got=%0d exp=0", acks); end
  endtask

  task automatic test_write_read;
    int lat; logic [255:0] rd; logic an;
    logic [255:0] pat;
    pat = {8{32'h1111_1111}};
    write_i = 1'b1; addr_i = 32'h0000_0040; data_i = pat; enable_i = 1'b1;
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("FAIL accept_busy got=%b exp=1", busy_o); end
    lat = -1; rd = '0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk_i); #1;
      if (ack_o === 1'b1) begin lat = n; rd = data_o; end
    end
    @(posedge clk_i); #1;
    an = ack_o;
    total++;
    if (lat != 10) begin bad++; $display("FAIL write_latency got=%0d exp=10", lat); end
    total++;
    if (an !== 1'b0) begin bad++; $display("FAIL write_ack_width got=%b exp=0", an); end
    total++;
    if (rd !== 256'h0) begin bad++; $display("FAIL write_keeps_data got=%h exp=0", rd); end
    run_req(1'b0, 32'h0000_0040, '0, lat, rd, an);
    total++;
    if (lat != 10) begin bad++; $display("FAIL read_latency got=%0d exp=10", lat); end
    total++;
    if (rd !== pat) begin bad++; $display("FAIL read_data got=%h exp=%h", rd, pat); end
    total++;
    if (an !== 1'b0) begin bad++; $display("FAIL read_ack_width got=%b exp=0", an); end
  endtask

  task automatic test_alias;
    int lat; logic [255:0] rd; logic an;
    logic [255:0] pat;
    pat = {8{32'hDEAD_BEEF}};
    run_req(1'b1, 32'h0000_0020, pat, lat, rd, an);
    run_req(1'b0, 32'h0000_403F, '0, lat, rd, an);
    total++;
    if (rd !== pat) begin bad++; $display("FAIL alias_read got=%h exp=%h", rd, pat); end
    total++;
    if (data_o !== pat) begin bad++; $display("FAIL data_hold got=%h exp=%h", data_o, pat); end
  endtask

  task automatic test_back_to_back;
    int first_ack; int second_ack; int ack_cnt;
    logic busy_k11; logic busy_k12;
    logic [255:0] pat;
    pat = {8{32'h1111_1111}};
    first_ack = -1; second_ack = -1; ack_cnt = 0;
    busy_k11 = 1'bx; busy_k12 = 1'bx;
    write_i = 1'b0; addr_i = 32'h0000_0040; data_i = '0; enable_i = 1'b1;
    @(posedge clk_i); #1;
    for (int n = 1; n <= 22; n++) begin
      @(posedge clk_i); #1;
      if (n == 11) busy_k11 = busy_o;
      if (n == 12) busy_k12 = busy_o;
      if (ack_o === 1'b1) begin
        ack_cnt++;
        if (first_ack < 0) first_ack = n;
        else second_ack = n;
      end
    end
    enable_i = 1'b0;
    total++;
    if (first_ack != 10) begin bad++; $display("FAIL b2b_first_ack got=%0d exp=10", first_ack); end
    total++;
    if (second_ack != 22) begin bad++; $display("FAIL b2b_second_ack got=%0d exp=22", second_ack); end
    total++;
    if (ack_cnt != 2) begin bad++; $display("FAIL b2b_ack_count got=%0d exp=2", ack_cnt); end
    total++;
    if (busy_k11 !== 1'b0) begin bad++; $display("FAIL b2b_no_accept_in_ack got=%b exp=0", busy_k11); end
    total++;
    if (busy_k12 !== 1'b1) begin bad++; $display("FAIL b2b_second_accept got=%b exp=1", busy_k12); end
    total++;
    if (data_o !== pat) begin bad++; $display("FAIL b2b_data got=%h exp=%h", data_o, pat); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_busy_change;
    int lat; logic [255:0] rd; logic an;
    logic [255:0] pat3; logic [255:0] pat7; logic [255:0] pat7_new;
    pat3 = {8{32'h3333_3333}};
    pat7 = {8{32'h0707_0707}};
    pat7_new = {8{32'h7777_7777}};
    run_req(1'b1, 32'h0000_00E0, pat7, lat, rd, an);
    write_i = 1'b1; addr_i = 32'h0000_0060; data_i = pat3; enable_i = 1'b1;
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end
    addr_i = 32'h0000_00E0; data_i = pat7_new; write_i = 1'b1;
    lat = 3;
    for (int n = 4; n <= 40 && lat == 3; n++) begin
      @(posedge clk_i); #1;
      if (ack_o === 1'b1) lat = n;
    end
    @(posedge clk_i); #1;
    total++;
    if (lat != 10) begin bad++; $display("FAIL chg_latency got=%0d exp=10", lat); end
    run_req(1'b0, 32'h0000_0060, '0, lat, rd, an);
    total++;
    if (rd !== pat3) begin bad++; $display("FAIL chg_orig_line got=%h exp=%h", rd, pat3); end
    run_req(1'b0, 32'h0000_00E0, '0, lat, rd, an);
    total++;
    if (rd !== pat7) begin bad++; $display("FAIL chg_new_line got=%h exp=%h", rd, pat7); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [255:0] rd; logic an; int acks;
    logic [255:0] pat5; logic [255:0] patA;
    pat5 = {8{32'h5555_5555}};
    patA = {8{32'hAAAA_AAAA}};
    run_req(1'b1, 32'h0000_00A0, pat5, lat, rd, an);
    write_i = 1'b1; addr_i = 32'h0000_00A0; data_i = patA; enable_i = 1'b1;
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    repeat (4) begin @(posedge clk_i); #1; end
    rst_i = 1'b0;
    #1;
    total++;
    if (busy_o !== 1'b0 || ack_o !== 1'b0) begin
      bad++; $display("FAIL mid_reset_outputs got busy=%b ack=%b exp busy=0 ack=0", busy_o, ack_o);
    end
    total++;
    if (data_o !== 256'h0) begin bad++; $display("FAIL mid_reset_data got=%h exp=0", data_o); end
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk_i); #1;
      if (ack_o === 1'b1) acks++;
    end
    total++;
    if (acks != 0) begin bad++; $display("FAIL mid_reset_no_ack got=%0d exp=0", acks); end
    run_req(1'b0, 32'h0000_00A0, '0, lat, rd, an);
    total++;
    if (rd !== pat5) begin bad++; $display("FAIL mid_reset_line5 got=%h exp=%h", rd, pat5); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_i = 1'b1;
    enable_i = 1'b0; write_i = 1'b0; addr_i = 32'h0; data_i = '0;
    #2;
    test_reset();
    test_write_read();
    test_alias();
    test_back_to_back();
    test_busy_change();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
